// File: rtl/fetch_stage.sv
// F stage: PC register, instruction-memory handshake with one-word skid buffer,
// and the IF/ID register; a branch target is held across a late delay slot.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc_i,
  input  logic        stall_i,
  output logic [31:0] pc_f_o,
  output logic        im_req_o,
  output logic [31:0] im_addr_o,
  input  logic        im_ack_i,
  input  logic [31:0] im_rdata_i,
  output logic [31:0] d_instr_o,
  output logic [31:0] d_pc_o,
  output logic [31:0] d_pc8_o,
  output logic        d_valid_o
);

  typedef enum logic {
    FETCH = 1'b0,
    BUF   = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] redir_q, redir_d;
  logic        redir_v_q, redir_v_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic        d_valid_q, d_valid_d;

  logic        avail;
  logic        xfer;
  logic [31:0] word;

  assign avail = ((state_q == FETCH) & im_ack_i) | (state_q == BUF);
  assign xfer  = avail & ~stall_i;
  assign word  = (state_q == BUF) ? buf_q : im_rdata_i;

  assign pc_f_o    = pc_q;
  assign im_req_o  = (state_q == FETCH) & ~reset;
  assign im_addr_o = pc_q;
  assign d_instr_o = d_instr_q;
  assign d_pc_o    = d_pc_q;
  assign d_pc8_o   = d_pc_q + 32'd8;
  assign d_valid_o = d_valid_q;

  // Next-state: transfer, capture into skid buffer, or insert a bubble.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_d     = buf_q;
    redir_d   = redir_q;
    redir_v_d = redir_v_q;
    d_instr_d = d_instr_q;
    d_pc_d    = d_pc_q;
    d_valid_d = d_valid_q;
    if (xfer) begin
      d_instr_d = word;
      d_pc_d    = pc_q;
      d_valid_d = 1'b1;
      pc_d      = redir_v_q ? redir_q : npc_i;
      redir_v_d = 1'b0;
      state_d   = FETCH;
    end else if (avail) begin
      if (state_q == FETCH) begin
        buf_d   = im_rdata_i;
        state_d = BUF;
      end
    end else if (!stall_i) begin
      d_instr_d = 32'd0;
      d_valid_d = 1'b0;
      if (d_valid_q) begin
        redir_d   = npc_i;
        redir_v_d = 1'b1;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      buf_q     <= 32'd0;
      redir_q   <= 32'd0;
      redir_v_q <= 1'b0;
      d_instr_q <= 32'd0;
      d_pc_q    <= RESET_PC;
      d_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      buf_q     <= buf_d;
      redir_q   <= redir_d;
      redir_v_q <= redir_v_d;
      d_instr_q <= d_instr_d;
      d_pc_q    <= d_pc_d;
      d_valid_q <= d_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized
// traffic checked against a transaction-level model.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] npc;
  logic        stall;
  logic [31:0] pc_f;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [31:0] d_pc8;
  logic        d_valid;

  int n_run  = 0;
  int n_fail = 0;

  // model state
  logic [31:0] m_pc;
  bit          m_held;
  logic [31:0] m_word;
  logic [31:0] m_redir[$];
  logic [31:0] m_di;
  logic [31:0] m_dpc;
  bit          m_dv;

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk       (clk),
    .reset     (reset),
    .npc_i     (npc),
    .stall_i   (stall),
    .pc_f_o    (pc_f),
    .im_req_o  (req),
    .im_addr_o (addr),
    .im_ack_i  (ack),
    .im_rdata_i(rdata),
    .d_instr_o (d_instr),
    .d_pc_o    (d_pc),
    .d_pc8_o   (d_pc8),
    .d_valid_o (d_valid)
  );

  always #5 clk = ~clk;

  function automatic void model_step();
    bit have;
    logic [31:0] w;
    if (reset) begin
      m_pc = RPC; m_held = 0; m_redir.delete();
      m_di = 0; m_dpc = RPC; m_dv = 0;
      return;
    end
    have = m_held || ack;
    w = m_held ? m_word : rdata;
    if (have && !stall) begin
      m_di = w; m_dpc = m_pc; m_dv = 1;
      if (m_redir.size() != 0) m_pc = m_redir.pop_front();
      else m_pc = npc;
      m_redir.delete();
      m_held = 0;
    end else if (have) begin
      if (!m_held) begin m_held = 1; m_word = rdata; end
    end else if (!stall) begin
      if (m_dv) begin m_redir.delete(); m_redir.push_back(npc); end
      m_di = 0; m_dv = 0;
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset(int n);
    reset = 1; ack = 0; stall = 0; npc = 0; rdata = 0;
    repeat (n) cycle();
    reset = 0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1; ack = 1; stall = 0; npc = 32'h1234; rdata = 32'hffff;
    cycle();
    n_run++; if (req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", req); end
    ack = 0;
    cycle();
    reset = 0; #1;
    n_run++; if (req !== 1'b1) begin n_fail++; $display("FAIL rst_req_after: got %b want 1", req); end
    n_run++; if (addr !== RPC) begin n_fail++; $display("FAIL rst_addr: got %h want %h", addr, RPC); end
    n_run++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dv: got %b want 0", d_valid); end
    n_run++; if (d_instr !== 32'd0) begin n_fail++; $display("FAIL rst_di: got %h want 0", d_instr); end
    n_run++; if (d_pc !== RPC) begin n_fail++; $display("FAIL rst_dpc: got %h want %h", d_pc, RPC); end
    n_run++; if (d_pc8 !== RPC + 8) begin n_fail++; $display("FAIL rst_dpc8: got %h want %h", d_pc8, RPC + 8); end
  endtask

  task automatic test_stream();
    logic [31:0] w;
    logic [31:0] e;
    do_reset(2);
    for (int i = 0; i < 3; i++) begin
      ack = 1; stall = 0; npc = m_pc + 4;
      w = $urandom; rdata = w;
      e = RPC + 32'(4 * i);
      cycle();
      n_run++; if (d_pc !== e) begin n_fail++; $display("FAIL stream_dpc%0d: got %h want %h", i, d_pc, e); end
      n_run++; if (d_valid !== 1'b1) begin n_fail++; $display("FAIL stream_dv%0d: got %b want 1", i, d_valid); end
      n_run++; if (d_instr !== w) begin n_fail++; $display("FAIL stream_di%0d: got %h want %h", i, d_instr, w); end
      n_run++; if (d_pc8 !== e + 8) begin n_fail++; $display("FAIL stream_pc8_%0d: got %h want %h", i, d_pc8, e + 8); end
    end
  endtask

  task automatic test_ack_delay();
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      ack = 0; npc = $urandom;
      n_run++; if (req !== 1'b1 || addr !== RPC) begin n_fail++; $display("FAIL dly_req%0d: got %b/%h want 1/%h", i, req, addr, RPC); end
      cycle();
      n_run++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL dly_dv%0d: got %b want 0", i, d_valid); end
    end
    ack = 1; npc = RPC + 4; rdata = 32'h2400_0001;
    cycle();
    n_run++; if (d_pc !== RPC || d_valid !== 1'b1) begin n_fail++; $display("FAIL dly_xfer: got %h/%b want %h/1", d_pc, d_valid, RPC); end
    n_run++; if (addr !== RPC + 4) begin n_fail++; $display("FAIL dly_next: got %h want %h", addr, RPC + 4); end
  endtask

  task automatic test_stall_on_ack();
    logic [31:0] w;
    w = $urandom;
    ack = 1; stall = 1; rdata = w; npc = $urandom;
    cycle();
    n_run++; if (req !== 1'b0) begin n_fail++; $display("FAIL stl_req: got %b want 0", req); end
    n_run++; if (d_pc !== RPC) begin n_fail++; $display("FAIL stl_dhold: got %h want %h", d_pc, RPC); end
    ack = 0; npc = $urandom; rdata = $urandom;
    cycle();
    n_run++; if (req !== 1'b0 || addr !== RPC + 4) begin n_fail++; $display("FAIL stl_hold: got %b/%h want 0/%h", req, addr, RPC + 4); end
    stall = 0; npc = 32'h3200;
    cycle();
    n_run++; if (d_pc !== RPC + 4 || d_instr !== w) begin n_fail++; $display("FAIL stl_rel: got %h/%h want %h/%h", d_pc, d_instr, RPC + 4, w); end
    n_run++; if (addr !== 32'h3200 || req !== 1'b1) begin n_fail++; $display("FAIL stl_next: got %h/%b want 3200/1", addr, req); end
  endtask

  task automatic test_stall_npc_change();
    ack = 1; stall = 1; npc = $urandom;
    cycle();
    ack = 0;
    for (int i = 0; i < 3; i++) begin
      npc = $urandom;
      cycle();
      n_run++; if (pc_f !== 32'h3200) begin n_fail++; $display("FAIL npc_ign%0d: got %h want 3200", i, pc_f); end
    end
    stall = 0; npc = 32'h3300; ack = 1;
    cycle();
    n_run++; if (d_pc !== 32'h3200 || addr !== 32'h3300) begin n_fail++; $display("FAIL npc_use: got %h/%h want 3200/3300", d_pc, addr); end
    ack = 0;
    cycle();
  endtask

  task automatic test_delay_slot_redirect();
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      ack = 1; stall = 0; npc = m_pc + 4; rdata = $urandom;
      cycle();
    end
    ack = 0; npc = 32'h3100;
    cycle();
    n_run++; if (d_valid !== 1'b0 || d_instr !== 32'd0) begin n_fail++; $display("FAIL ds_bub: got %b/%h want 0/0", d_valid, d_instr); end
    n_run++; if (d_pc !== 32'h3008 || addr !== 32'h300c) begin n_fail++; $display("FAIL ds_hold: got %h/%h want 3008/300c", d_pc, addr); end
    npc = 32'h3abc;
    cycle();
    ack = 1; npc = 32'h3def; rdata = 32'h0000_0000;
    cycle();
    n_run++; if (d_pc !== 32'h300c || d_valid !== 1'b1) begin n_fail++; $display("FAIL ds_slot: got %h/%b want 300c/1", d_pc, d_valid); end
    n_run++; if (addr !== 32'h3100) begin n_fail++; $display("FAIL ds_tgt: got %h want 3100", addr); end
  endtask

  task automatic test_reset_mid_request();
    do_reset(1);
    ack = 1; npc = 32'h3040; rdata = $urandom;
    cycle();
    ack = 0; npc = $urandom;
    cycle();
    n_run++; if (addr !== 32'h3040 || req !== 1'b1) begin n_fail++; $display("FAIL rmr_wait: got %h/%b want 3040/1", addr, req); end
    reset = 1; ack = 1; #1;
    n_run++; if (req !== 1'b0) begin n_fail++; $display("FAIL rmr_req: got %b want 0", req); end
    cycle();
    reset = 0; ack = 0; #1;
    n_run++; if (addr !== RPC || req !== 1'b1) begin n_fail++; $display("FAIL rmr_addr: got %h/%b want %h/1", addr, req, RPC); end
    n_run++; if (d_valid !== 1'b0 || d_instr !== 32'd0) begin n_fail++; $display("FAIL rmr_d: got %b/%h want 0/0", d_valid, d_instr); end
  endtask

  task automatic test_random();
    bit er;
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      ack   = ($urandom_range(0, 1) == 1);
      stall = ($urandom_range(0, 9) < 3);
      npc   = $urandom;
      rdata = $urandom;
      cycle();
      er = !m_held && !reset;
      n_run++; if (req !== er) begin n_fail++; $display("FAIL rnd_req@%0d: got %b want %b", i, req, er); end
      n_run++; if (addr !== m_pc) begin n_fail++; $display("FAIL rnd_addr@%0d: got %h want %h", i, addr, m_pc); end
      n_run++; if (d_valid !== m_dv) begin n_fail++; $display("FAIL rnd_dv@%0d: got %b want %b", i, d_valid, m_dv); end
      n_run++; if (d_instr !== m_di) begin n_fail++; $display("FAIL rnd_di@%0d: got %h want %h", i, d_instr, m_di); end
      n_run++; if (d_pc !== m_dpc) begin n_fail++; $display("FAIL rnd_dpc@%0d: got %h want %h", i, d_pc, m_dpc); end
      n_run++; if (d_pc8 !== m_dpc + 32'd8) begin n_fail++; $display("FAIL rnd_pc8@%0d: got %h want %h", i, d_pc8, m_dpc + 32'd8); end
    end
  endtask

  initial begin
    reset = 1; npc = 0; stall = 0; ack = 0; rdata = 0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_ack_delay();
    test_stall_on_ack();
    test_stall_npc_change();
    test_delay_slot_redirect();
    test_reset_mid_request();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
